// File: rtl/fft_pkg.sv
// Shared FFT types: twiddle beat bundle, fetch FSM states, Q1.15 helpers.
// Widths here match the default twiddle_fetch build (N=1024, 16-bit).
package fft_pkg;
  localparam int FFT_N_LOG2 = 10;
  localparam int TW_ADDR_W = FFT_N_LOG2 - 1;
  localparam int TW_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } tf_state_t;

  typedef struct packed {
    logic [TW_DATA_W-1:0] re;
    logic [TW_DATA_W-1:0] im;
    logic [3:0]           stage;
    logic [TW_ADDR_W-1:0] bfly;
    logic                 last;
  } twiddle_t;

  // -x with the most negative code clamped to the most positive
  function automatic logic [TW_DATA_W-1:0] sat_neg(
    input logic [TW_DATA_W-1:0] x
  );
    if (x == {1'b1, {(TW_DATA_W-1){1'b0}}})
      return ~x;
    return -x;
  endfunction
endpackage

// File: rtl/tw_fifo2.sv
// Two-entry FIFO of twiddle beats; push and pop may coincide.
// Head entry is presented combinationally on o_data.
module tw_fifo2
  import fft_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  twiddle_t   i_data,
  output twiddle_t   o_data,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);
  twiddle_t   r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/twiddle_fetch.sv
// FFT twiddle ROM read initiator: walks stages/butterflies, streams tagged twiddles.
// TWIDDLE_FETCH_INVERSE_EN adds i_inverse for conjugated (IFFT) twiddles.
module twiddle_fetch
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DATA_W = TW_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
`ifdef TWIDDLE_FETCH_INVERSE_EN
  input  logic              i_inverse,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [N_LOG2-2:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data_re,
  input  logic [DATA_W-1:0] i_rd_data_im,
  output logic              o_tw_valid,
  input  logic              i_tw_ready,
  output logic [DATA_W-1:0] o_tw_re,
  output logic [DATA_W-1:0] o_tw_im,
  output logic [3:0]        o_tw_stage,
  output logic [N_LOG2-2:0] o_tw_bfly,
  output logic              o_tw_last
);
  localparam int AW = N_LOG2 - 1;
  localparam logic [3:0]    S_LAST = 4'(N_LOG2 - 1);
  localparam logic [AW-1:0] B_LAST = '1;

  tf_state_t     r_state;
  logic [3:0]    r_s;
  logic [AW-1:0] r_b;
  logic          r_inflight;
  logic [3:0]    r_tag_s;
  logic [AW-1:0] r_tag_b;
  logic          r_tag_last;
  logic          r_busy;
  logic          r_done;
`ifdef TWIDDLE_FETCH_INVERSE_EN
  logic          r_inv;
`endif

  logic          w_issue;
  logic          w_req_last;
  logic [1:0]    w_count;
  logic [1:0]    w_sum;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [AW:0]   w_mask;
  logic [AW-1:0] w_addr;
  logic [DATA_W-1:0] w_im;
  twiddle_t      w_push_d;
  twiddle_t      w_head;

  assign w_sum   = w_count + {1'b0, r_inflight};
  assign w_issue = (r_state == RUN) & (w_sum < 2'd2) & ~w_full;
  assign w_pop   = ~w_empty & i_tw_ready;
  assign w_req_last = (r_s == S_LAST) & (r_b == B_LAST);

  // Mask is one bit wider so 2^s - 1 never wraps at the top stage
  assign w_mask = ((AW+1)'(1) << r_s) - (AW+1)'(1);
  assign w_addr = (r_b & w_mask[AW-1:0]) << (4'(AW) - r_s);

`ifdef TWIDDLE_FETCH_INVERSE_EN
  assign w_im = r_inv ? sat_neg(i_rd_data_im) : i_rd_data_im;
`else
  assign w_im = i_rd_data_im;
`endif

  assign w_push_d = '{
    re:    i_rd_data_re,
    im:    w_im,
    stage: r_tag_s,
    bfly:  r_tag_b,
    last:  r_tag_last
  };

  tw_fifo2 u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (w_push_d),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_s        <= '0;
      r_b        <= '0;
      r_inflight <= 1'b0;
      r_tag_s    <= '0;
      r_tag_b    <= '0;
      r_tag_last <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef TWIDDLE_FETCH_INVERSE_EN
      r_inv      <= 1'b0;
`endif
    end else begin
      r_inflight <= w_issue;
      r_done     <= 1'b0;
      if (w_issue) begin
        r_tag_s    <= r_s;
        r_tag_b    <= r_b;
        r_tag_last <= w_req_last;
        if (r_b == B_LAST) begin
          r_b <= '0;
          r_s <= r_s + 4'd1;
        end else begin
          r_b <= r_b + AW'(1);
        end
      end
      unique case (r_state)
        IDLE: if (i_start) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
          r_s     <= '0;
          r_b     <= '0;
`ifdef TWIDDLE_FETCH_INVERSE_EN
          r_inv   <= i_inverse;
`endif
        end
        RUN: if (w_issue & w_req_last)
          r_state <= DRAIN;
        // Finish once the final beat leaves this cycle or already has
        DRAIN: if (~r_inflight &
                   (w_empty | ((w_count == 2'd1) & w_pop))) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rd_en    = w_issue;
  assign o_rd_addr  = w_issue ? w_addr : '0;
  assign o_tw_valid = ~w_empty;
  assign o_tw_re    = w_head.re;
  assign o_tw_im    = w_head.im;
  assign o_tw_stage = w_head.stage;
  assign o_tw_bfly  = w_head.bfly;
  assign o_tw_last  = w_head.last;
endmodule

// File: tb/tb_twiddle_fetch.sv
// Bench for twiddle_fetch: ROM model, beat scoreboard, vector table.
// Define TWIDDLE_FETCH_INVERSE_EN to also exercise the conjugate sweep.
module tb_twiddle_fetch;
  localparam int NL = 10;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NB = 512;
  localparam int NBEAT = 5120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready;
  logic inverse = 1'b0;
  logic busy, done, rd_en, tw_valid, tw_last;
  logic [AW-1:0] rd_addr, tw_bfly;
  logic [DW-1:0] rd_re, rd_im, tw_re, tw_im;
  logic [3:0] tw_stage;

  always #5 clk = ~clk;

  twiddle_fetch dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
`ifdef TWIDDLE_FETCH_INVERSE_EN
    .i_inverse    (inverse),
`endif
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data_re (rd_re),
    .i_rd_data_im (rd_im),
    .o_tw_valid   (tw_valid),
    .i_tw_ready   (ready),
    .o_tw_re      (tw_re),
    .o_tw_im      (tw_im),
    .o_tw_stage   (tw_stage),
    .o_tw_bfly    (tw_bfly),
    .o_tw_last    (tw_last)
  );

  typedef struct packed {
    logic [3:0]    s;
    logic [AW-1:0] b;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } beat_t;

  typedef struct {
    int s;
    int b;
    int addr;
    int chkd;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } vec_t;

  logic [DW-1:0] rom_re [NB];
  logic [DW-1:0] rom_im [NB];
  logic [DW-1:0] bl_re [NBEAT];
  logic [DW-1:0] bl_im [NBEAT];
  logic [AW-1:0] addr_log [NBEAT];
  beat_t sbq [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_beat = 0;
  int n_done = 0;
  int n_last = 0;
  int n_rd = 0;
  int last_hs = -10;
  bit rmode = 1'b0;
  logic [DW-1:0] inv_im11 = '0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic logic [DW-1:0] q15(input real v);
    real r;
    int i;
    r = v * 32768.0;
    i = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    if (i > 32767) i = 32767;
    if (i < -32768) i = -32768;
    return DW'(i);
  endfunction

  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    return 16'(32'h10000 - {16'h0, x});
  endfunction

  // ROM pair: registered read, zero when not enabled
  always @(posedge clk) begin
    rd_re <= rd_en ? rom_re[rd_addr] : '0;
    rd_im <= rd_en ? rom_im[rd_addr] : '0;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready = rmode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic push_expect(input bit inv);
    beat_t e;
    int a;
    for (int s = 0; s < NL; s++)
      for (int b = 0; b < NB; b++) begin
        a = (b % (1 << s)) * (1 << (AW - s));
        e.s = 4'(s);
        e.b = AW'(b);
        e.re = rom_re[a];
        e.im = inv ? neg_sat(rom_im[a]) : rom_im[a];
        e.last = (s == NL - 1) && (b == NB - 1);
        sbq.push_back(e);
      end
  endtask

  // Monitor: scoreboard pops, stall hold, issue rule, done timing
  initial begin
    int m_cnt;
    bit m_infl;
    bit stall_p;
    beat_t cur, prev, e;
    m_cnt = 0;
    m_infl = 0;
    stall_p = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_cnt = 0;
        m_infl = 0;
        stall_p = 0;
        continue;
      end
      cur = '{tw_stage, tw_bfly, tw_re, tw_im, tw_last};
      if (stall_p) chk("stall_hold", 64'(cur), 64'(prev));
      chk("valid_vs_model", 64'(tw_valid), 64'(m_cnt != 0));
      if (rd_en) begin
        chk("rd_room", 64'(m_cnt + int'(m_infl) < 2), 64'd1);
        if (n_rd < NBEAT) addr_log[n_rd] = rd_addr;
        n_rd++;
      end
      if (tw_valid && ready) begin
        if (sbq.size() == 0) begin
          chk("extra_beat", 64'(cur), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("beat", 64'(cur), 64'(e));
        end
        if (n_beat < NBEAT) begin
          bl_re[n_beat] = tw_re;
          bl_im[n_beat] = tw_im;
        end
        if (tw_stage == 4'd1 && tw_bfly == 9'd1) inv_im11 = tw_im;
        n_beat++;
        if (tw_last) n_last++;
        last_hs = cyc;
      end
      if (done) begin
        n_done++;
        chk("done_timing", 64'(cyc), 64'(last_hs + 1));
      end
      m_cnt = m_cnt + int'(m_infl) - int'(tw_valid && ready);
      m_infl = rd_en;
      stall_p = tw_valid && !ready;
      prev = cur;
    end
  end

  task automatic do_start(input bit inv);
    @(posedge clk);
    #1;
    inverse = inv;
    push_expect(inv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk("done_timeout", 64'(n_done > d0), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_outs_zero(input string nm);
    chk(nm, {busy, done, rd_en, rd_addr, tw_valid, tw_re, tw_im,
             tw_stage, tw_bfly, tw_last}, 64'd0);
  endtask

  initial begin
    vec_t tv [6];
    int b0, d0, l0, lat, k, z;
    tv[0] = '{0, 0, 0, 1, 16'h7FFF, 16'h0000};
    tv[1] = '{0, 300, 0, 1, 16'h7FFF, 16'h0000};
    tv[2] = '{1, 1, 256, 1, 16'h0000, 16'h8000};
    tv[3] = '{9, 1, 1, 0, 16'h0000, 16'h0000};
    tv[4] = '{9, 511, 511, 0, 16'h0000, 16'h0000};
    tv[5] = '{2, 3, 384, 1, 16'hA57E, 16'hA57E};
    for (int i = 0; i < NB; i++) begin
      rom_re[i] = q15($cos(2.0 * 3.14159265358979 * i / 1024.0));
      rom_im[i] = q15(-$sin(2.0 * 3.14159265358979 * i / 1024.0));
    end

    repeat (4) @(posedge clk);
    #1;
    check_outs_zero("reset_outs");
    rst_n = 1'b1;

    // Run A: ready high, latency, addresses, done
    b0 = n_beat;
    l0 = n_last;
    do_start(1'b0);
    chk("busy_rise", 64'(busy), 64'd1);
    lat = 1;
    while (!tw_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_lat", 64'(lat), 64'd3);
    chk("first_beat", {tw_stage, tw_bfly, tw_re, tw_im},
        {4'd0, 9'd0, 16'h7FFF, 16'h0000});
    wait_done(20000);
    chk("beats_a", 64'(n_beat - b0), 64'(NBEAT));
    chk("last_a", 64'(n_last - l0), 64'd1);
    chk("done_a", 64'(n_done), 64'd1);
    chk("busy_fall", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      k = tv[i].s * NB + tv[i].b;
      chk($sformatf("addr_s%0d_b%0d", tv[i].s, tv[i].b),
          64'(addr_log[k]), 64'(tv[i].addr));
      if (tv[i].chkd != 0)
        chk($sformatf("data_s%0d_b%0d", tv[i].s, tv[i].b),
            {bl_re[k], bl_im[k]}, {tv[i].re, tv[i].im});
    end
    z = 0;
    for (int i = 0; i < NB; i++)
      if (addr_log[i] != '0) z++;
    chk("stage0_addr", 64'(z), 64'd0);

    // Run B: random ready, start re-pulsed mid-sweep
    rmode = 1'b1;
    b0 = n_beat;
    d0 = n_done;
    do_start(1'b0);
    repeat (200) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40000);
    chk("beats_b", 64'(n_beat - b0), 64'(NBEAT));
    chk("done_b", 64'(n_done - d0), 64'd1);
    chk("sb_empty_b", 64'(sbq.size()), 64'd0);
    rmode = 1'b0;

    // Run C: reset at beat 1000, then a clean restart
    b0 = n_beat;
    d0 = n_done;
    do_start(1'b0);
    k = 0;
    while (n_beat < b0 + 1000 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_1000", 64'(n_beat >= b0 + 1000), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs_zero("mid_reset_outs");
    sbq.delete();
    repeat (4) @(posedge clk);
    chk("no_done_reset", 64'(n_done - d0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b0 = n_beat;
    do_start(1'b0);
    wait_done(20000);
    chk("beats_c", 64'(n_beat - b0), 64'(NBEAT));
    chk("done_c", 64'(n_done - d0), 64'd1);

`ifdef TWIDDLE_FETCH_INVERSE_EN
    b0 = n_beat;
    do_start(1'b1);
    wait_done(20000);
    chk("beats_inv", 64'(n_beat - b0), 64'(NBEAT));
    chk("inv_s1_b1", 64'(inv_im11), 64'h7FFF);
    inverse = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/twiddle_fetch.md
Name: twiddle_fetch

Overview:
- Read-side initiator for the FFT twiddle ROM pair (one real bank, one imaginary bank; 512 x 16 each, Q1.15, entry k = W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N)).
- Walks every radix-2 DIT stage and butterfly and issues ROM read requests.
- Absorbs the ROM's 1-cycle registered read latency.
- Delivers twiddles to the butterfly datapath on a valid/ready stream, in strict butterfly order, with stage/index tags.

Parameters:
- N_LOG2, 10, log2 of FFT length. The ROM depth is 2^(N_LOG2-1).
- DATA_W, 16, twiddle component width (Q1.15).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  single-cycle pulse; begins a full twiddle sweep when idle
- o_busy  out  1  high from the accepted start until o_done
- o_done  out  1  one-cycle pulse after the last twiddle handshake
- o_rd_en  out  1  ROM read enable, driven to both banks
- o_rd_addr  out  N_LOG2-1  ROM address
- i_rd_data_re  in  DATA_W  real-bank data, valid the cycle after o_rd_en
- i_rd_data_im  in  DATA_W  imaginary-bank data, same timing
- o_tw_valid  out  1  twiddle stream valid
- i_tw_ready  in  1  consumer ready
- o_tw_re  out  DATA_W  twiddle real part
- o_tw_im  out  DATA_W  twiddle imaginary part
- o_tw_stage  out  4  stage s of the current beat
- o_tw_bfly  out  N_LOG2-1  butterfly index b of the current beat
- o_tw_last  out  1  high on the final beat (s=N_LOG2-1, b=max)

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters 0; FIFO empty; any in-flight read discarded.
- FSM states:
  - IDLE: on i_start go to RUN. o_busy rises the next cycle.
  - RUN: issue reads; after the request for (s=N_LOG2-1, b=2^(N_LOG2-1)-1) go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty after the last handshake; then go to DONE.
  - DONE: o_done=1 for one cycle; o_busy=0; return to IDLE.
- i_start outside IDLE is ignored.
- Sweep order: s from 0 to N_LOG2-1 (outer), b from 0 to 2^(N_LOG2-1)-1 (inner). Total 5120 beats at default.
- Address: addr = (b & (2^s - 1)) << (N_LOG2-1-s), computed at full width with no wrap. Stage 0 always gives addr 0.
- Read issue: o_rd_en=1 in a cycle only if in RUN and fifo_count + inflight < 2.
  - inflight is a 1-bit register equal to the previous cycle's o_rd_en.
  - When a read is issued, b/s advance the same cycle.
- Capture: when inflight=1, push {i_rd_data_re, i_rd_data_im, tag s/b/last of that request} into the 2-entry FIFO.
  - ROM data is captured only in the inflight cycle, because the ROM outputs 0 when not enabled.
- Output: o_tw_* present the FIFO head; o_tw_valid = FIFO not empty.
  - A pop occurs on o_tw_valid & i_tw_ready.
  - Push and pop in the same cycle are allowed; count stays the same.
  - With i_tw_ready held high, throughput is 1 beat/cycle.
  - Latency from the i_start pulse to the first o_tw_valid is 3 cycles.
- Stall: if i_tw_ready is low, o_tw_* hold stable and the FIFO never overflows, because the issue rule guarantees room.
- o_done fires exactly once per sweep, the cycle after DRAIN completes.
- Reset mid-sweep returns everything to the reset state immediately; no o_done is produced.

Optional Feature:
- Macro TWIDDLE_FETCH_INVERSE_EN.
- When defined:
  - Extra port i_inverse (in, 1) is sampled at the accepted i_start and held for the sweep.
  - When set, o_tw_im = saturating negate of the ROM imaginary value, producing conj(W) for the IFFT. 0x8000 maps to 0x7FFF; 0x0000 stays 0x0000.
  - Negation is applied at FIFO push; latency is unchanged.
- When undefined: the port is absent and data passes through unmodified.

Decomposition:
- fft_pkg holds:
  - FFT_N_LOG2, TW_ADDR_W, TW_DATA_W.
  - typedef twiddle_t: packed struct {re, im, stage, bfly, last}.
  - FSM enum tf_state_t {IDLE, RUN, DRAIN, DONE}.
- One sub-module, tw_fifo2: 2-entry FIFO of twiddle_t.
  - Ports: push, pop, full, empty, count.
  - Supports simultaneous push/pop.
  - Reset is asynchronous active-low, on i_rst_n.

Test Plan:
- Ready always 1, ROM model attached. Pulse i_start and check:
  - 5120 beats total.
  - First beat appears 3 cycles after start: s=0, b=0, re=0x7FFF, im=0x0000.
  - o_tw_last appears only on the final beat.
  - o_done fires the cycle after the final beat.
- Address check:
  - s=1, b=1: addr 256, re=0x0000, im=0x8000.
  - s=9, b=1: addr 1.
  - s=9, b=511: addr 511.
  - All stage-0 beats: addr 0.
- Random i_tw_ready (about 30% duty):
  - Beat sequence is identical to the ready=1 run.
  - Data holds stable whenever valid=1 and ready=0.
  - o_rd_en never fires while FIFO count + inflight = 2.
- i_start re-pulsed during RUN: ignored; still exactly 5120 beats and one o_done.
- i_rst_n asserted at beat 1000: all outputs 0 asynchronously; o_done never pulses. A subsequent i_start restarts the sweep from s=0, b=0.
- TWIDDLE_FETCH_INVERSE_EN defined, i_inverse=1: the s=1, b=1 beat gives im=0x7FFF, and every other im equals the negated forward value.
